// File: rtl/mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : mul_iter
// Description : Iterative 32x32 shift-add multiplier (MULT/MULTU), one
//               partial product per cycle, 64-bit {HI,LO} result.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_iter #(
    parameter int ZERO_SHORTCUT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_mul_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]  r_state,  w_state_nxt;
    logic [63:0] r_mcand,  w_mcand_nxt;
    logic [31:0] r_mplier, w_mplier_nxt;
    logic [63:0] r_acc,    w_acc_nxt;
    logic [5:0]  r_cnt,    w_cnt_nxt;
    logic        r_sign1,  w_sign1_nxt;
    logic        r_sign2,  w_sign2_nxt;
    logic [63:0] r_result, w_result_nxt;
    logic        r_ready,  w_ready_nxt;

    logic        w_neg1, w_neg2, w_zero_op;
    logic [31:0] w_mag1, w_mag2;
    logic [63:0] w_acc_sum;

    // Magnitudes are taken as unsigned, so 0x80000000 yields 2^31 cleanly.
    assign w_neg1    = opdata1_i[31] & signed_mul_i;
    assign w_neg2    = opdata2_i[31] & signed_mul_i;
    assign w_mag1    = w_neg1 ? (~opdata1_i + 32'd1) : opdata1_i;
    assign w_mag2    = w_neg2 ? (~opdata2_i + 32'd1) : opdata2_i;
    assign w_zero_op = (ZERO_SHORTCUT != 0) && ((opdata1_i == 32'd0) || (opdata2_i == 32'd0));
    assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : 64'd0);

    always_comb begin
        w_state_nxt  = r_state;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_sign1_nxt  = r_sign1;
        w_sign2_nxt  = r_sign2;
        w_result_nxt = r_result;
        w_ready_nxt  = r_ready;
        case (r_state)
            c_ST_IDLE: begin
                w_result_nxt = 64'd0;
                w_ready_nxt  = 1'b0;
                if (start_i && !annul_i) begin
                    w_sign1_nxt  = w_neg1;
                    w_sign2_nxt  = w_neg2;
                    w_mcand_nxt  = {32'd0, w_mag1};
                    w_mplier_nxt = w_mag2;
                    w_acc_nxt    = 64'd0;
                    w_cnt_nxt    = 6'd0;
                    if (w_zero_op) begin
                        w_state_nxt = c_ST_DONE;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_BUSY;
                    end
                end
            end
            c_ST_BUSY: begin
                if (annul_i) begin
                    w_state_nxt  = c_ST_IDLE;
                    w_result_nxt = 64'd0;
                    w_ready_nxt  = 1'b0;
                end else begin
                    w_acc_nxt    = w_acc_sum;
                    w_mcand_nxt  = {r_mcand[62:0], 1'b0};
                    w_mplier_nxt = {1'b0, r_mplier[31:1]};
                    w_cnt_nxt    = r_cnt + 6'd1;
                    // Counter reads 31 on the edge performing the 32nd iteration.
                    if (r_cnt == 6'd31) begin
                        w_state_nxt  = c_ST_DONE;
                        w_ready_nxt  = 1'b1;
                        w_result_nxt = (r_sign1 ^ r_sign2) ? (~w_acc_sum + 64'd1) : w_acc_sum;
                    end
                end
            end
            c_ST_DONE: begin
                if (!start_i) begin
                    w_state_nxt  = c_ST_IDLE;
                    w_result_nxt = 64'd0;
                    w_ready_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = c_ST_IDLE;
                w_result_nxt = 64'd0;
                w_ready_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_mcand  <= 64'd0;
            r_mplier <= 32'd0;
            r_acc    <= 64'd0;
            r_cnt    <= 6'd0;
            r_sign1  <= 1'b0;
            r_sign2  <= 1'b0;
            r_result <= 64'd0;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sign1  <= w_sign1_nxt;
            r_sign2  <= w_sign2_nxt;
            r_result <= w_result_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule
`default_nettype wire

// File: doc/mul_iter.md
MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 SHALL provide parameter: ZERO_SHORTCUT, default 1, when 1 a zero operand completes without iterating.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL provide port: signed_mul_i  input  1  1 = signed (MULT), 0 = unsigned (MULTU).
REQ-005 SHALL provide port: opdata1_i  input  32  multiplicand from EX.
REQ-006 SHALL provide port: opdata2_i  input  32  multiplier from EX.
REQ-007 SHALL provide port: start_i  input  1  request from EX; held high until ready_o is seen, then dropped.
REQ-008 SHALL provide port: annul_i  input  1  abort the operation in progress.
REQ-009 SHALL provide port: result_o  output  64  product {HI,LO}.
REQ-010 SHALL provide port: ready_o  output  1  result_o valid.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, BUSY, DONE; result_o and ready_o registered.
REQ-012 IDLE: SHALL accept when start_i=1 and annul_i=0; otherwise stay IDLE with ready_o=0 and result_o=0.
REQ-013 On acceptance SHALL latch sign1=opdata1_i[31]&signed_mul_i and sign2=opdata2_i[31]&signed_mul_i, latch operand magnitudes (two's complement of a negative signed operand, else raw value), clear the 64-bit accumulator, clear the 6-bit iteration counter, and enter BUSY.
REQ-014 With ZERO_SHORTCUT=1 and either operand 0 at acceptance, SHALL go directly to DONE with result_o=0 and ready_o=1 on the accepting edge.
REQ-015 BUSY, each edge: if multiplier LSB=1, accumulator += 64-bit multiplicand; multiplicand shifts left 1; multiplier shifts right 1; counter increments.
REQ-016 On the edge performing iteration 32, SHALL enter DONE, load result_o with the final accumulator (negated mod 2^64 when sign1^sign2=1), and set ready_o=1; ready_o is first high in the cycle after the 32nd edge following acceptance.
REQ-017 Magnitude of 0x80000000 SHALL be treated as unsigned 2^31 (no overflow).
REQ-018 BUSY with annul_i=1 SHALL return to IDLE on that edge, ready_o=0, result_o=0, no iteration performed.
REQ-019 start_i dropping during BUSY SHALL NOT abort; only annul_i aborts.
REQ-020 DONE: SHALL hold result_o and ready_o=1 while start_i=1; annul_i ignored in DONE.
REQ-021 DONE with start_i=0 SHALL return to IDLE, clearing ready_o and result_o on that edge.
REQ-022 Operand input changes after acceptance SHALL NOT affect the operation.
REQ-023 A new request SHALL be accepted only from IDLE; back-to-back ops need at least one IDLE cycle between DONE and the next acceptance.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE, ready_o=0, result_o=0, accumulator and counter 0, regardless of state or start_i/annul_i.
REQ-025 Reset mid-BUSY SHALL discard the operation; no ready_o pulse follows.
REQ-026 After rst falls, the first edge with start_i=1 SHALL be accepted normally.

Verification
REQ-027 Unsigned 7 x 6, start held -> ready_o high 32 edges after acceptance, result_o=0x000000000000002A; drop start -> ready_o=0 next cycle.
REQ-028 Signed 0xFFFFFFFD x 0x00000005 -> result_o=0xFFFFFFFFFFFFFFF1; same operands unsigned -> 0x00000004FFFFFFF1.
REQ-029 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE00000001; signed 0x80000000 x 0x80000000 -> 0x4000000000000000.
REQ-030 Operands 0x00000000 x 0x12345678, ZERO_SHORTCUT=1 -> ready_o high the cycle after acceptance, result_o=0.
REQ-031 annul_i=1 on the 10th BUSY edge -> IDLE, ready_o never rises; a new 3 x 3 request next cycle -> 0x9 after 32 edges.
REQ-032 rst=1 on the 20th BUSY edge -> ready_o=0, result_o=0; start_i held through reset -> reaccepted on the first edge after reset and completes normally.
